// File: rtl/histogram_readout_control.sv
// Streams a finished histogram out of scratch memory as a saturating running CDF,
// clearing each bin behind the read so the memory is ready for the next frame.
module histogram_readout_control #(
    parameter int NUM_BINS     = 256,
    parameter int ADDR_WIDTH   = 8,
    parameter int BIN_WIDTH    = 16,
    parameter int CDF_WIDTH    = 20,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_readout,
    output logic [ADDR_WIDTH-1:0] scratch_mem_read_address,
    output logic                  scratch_mem_read_enable,
    input  logic [BIN_WIDTH-1:0]  scratch_mem_read_data,
    output logic [ADDR_WIDTH-1:0] scratch_mem_write_address,
    output logic                  scratch_mem_write_enable,
    output logic [BIN_WIDTH-1:0]  scratch_mem_write_data,
    output logic                  cdf_valid,
    input  logic                  cdf_ready,
    output logic [ADDR_WIDTH-1:0] cdf_bin,
    output logic [CDF_WIDTH-1:0]  cdf_data,
    output logic                  cdf_last,
    output logic                  readout_busy,
    output logic                  readout_done
);

    localparam int SUM_WIDTH  = ((CDF_WIDTH > BIN_WIDTH) ? CDF_WIDTH : BIN_WIDTH) + 1;
    localparam int WAIT_WIDTH = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(READ_LATENCY - 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN  = ADDR_WIDTH'(NUM_BINS - 1);
    localparam logic [CDF_WIDTH-1:0]  CDF_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_ADDR = 3'd1,
        WAIT     = 3'd2,
        CAPTURE  = 3'd3,
        CLEAR    = 3'd4,
        OUTPUT   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   bin_count;
    logic [CDF_WIDTH-1:0]    accum;
    logic [WAIT_WIDTH-1:0]   wait_count;

    function automatic logic [CDF_WIDTH-1:0] sat_add(input logic [CDF_WIDTH-1:0] acc,
                                                     input logic [BIN_WIDTH-1:0] bin);
        logic [SUM_WIDTH-1:0] sum;
        sum = SUM_WIDTH'(acc) + SUM_WIDTH'(bin);
        if (sum > SUM_WIDTH'(CDF_MAX)) begin
            return CDF_MAX;
        end
        return sum[CDF_WIDTH-1:0];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            bin_count  <= '0;
            accum      <= '0;
            wait_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    bin_count <= '0;
                    accum     <= '0;
                end
                SET_ADDR: wait_count <= WAIT_LOAD;
                WAIT: begin
                    if (wait_count != '0) begin
                        wait_count <= wait_count - 1'b1;
                    end
                end
                // read data lands in this cycle; fold it straight into the running sum
                CAPTURE: accum <= sat_add(accum, scratch_mem_read_data);
                OUTPUT: begin
                    if (cdf_ready && (bin_count != LAST_BIN)) begin
                        bin_count <= bin_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next               = state;
        scratch_mem_read_enable  = 1'b0;
        scratch_mem_write_enable = 1'b0;
        cdf_valid                = 1'b0;
        cdf_last                 = 1'b0;
        readout_done             = 1'b0;
        case (state)
            IDLE: begin
                if (start_readout) begin
                    state_next = SET_ADDR;
                end
            end
            SET_ADDR: begin
                scratch_mem_read_enable = !reset;
                state_next              = WAIT;
            end
            WAIT: begin
                if (wait_count == '0) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = CLEAR;
            CLEAR: begin
                // a reset landing on this cycle must not leave a half-issued clear behind
                scratch_mem_write_enable = !reset;
                state_next               = OUTPUT;
            end
            OUTPUT: begin
                cdf_valid = 1'b1;
                cdf_last  = (bin_count == LAST_BIN);
                if (cdf_ready) begin
                    state_next = (bin_count == LAST_BIN) ? DONE : SET_ADDR;
                end
            end
            DONE: begin
                readout_done = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign scratch_mem_read_address  = bin_count;
    assign scratch_mem_write_address = bin_count;
    assign scratch_mem_write_data    = '0;
    assign cdf_bin                   = bin_count;
    assign cdf_data                  = accum;
    assign readout_busy              = (state != IDLE);

endmodule

// File: tb/tb_histogram_readout_control.sv
// Bench for histogram_readout_control: scratch memory model with 3-cycle read latency,
// randomized bin contents and backpressure, checked against a prefix-sum model.
module tb_histogram_readout_control;

    localparam int     NB         = 256;
    localparam int     RL         = 3;
    localparam int     DONE_REL   = (RL + 3) * NB + 1;
    localparam longint CDF_MAX20  = 64'd1048575;
    localparam longint CDF_MAX16  = 64'd65535;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // main instance (default widths)
    logic        start = 1'b0;
    logic        cdf_ready = 1'b1;
    logic [7:0]  rd_addr, wr_addr, cdf_bin;
    logic        rd_en, wr_en, cdf_valid, cdf_last, busy, done;
    logic [15:0] rd_data, wr_data;
    logic [19:0] cdf_data;

    // 16-bit CDF instance
    logic        s_start = 1'b0;
    logic        s_ready = 1'b1;
    logic [7:0]  s_rd_addr, s_wr_addr, s_cdf_bin;
    logic        s_rd_en, s_wr_en, s_cdf_valid, s_cdf_last, s_busy, s_done;
    logic [15:0] s_rd_data, s_wr_data;
    logic [15:0] s_cdf_data;

    histogram_readout_control dut (
        .clock(clock), .reset(reset), .start_readout(start),
        .scratch_mem_read_address(rd_addr), .scratch_mem_read_enable(rd_en),
        .scratch_mem_read_data(rd_data),
        .scratch_mem_write_address(wr_addr), .scratch_mem_write_enable(wr_en),
        .scratch_mem_write_data(wr_data),
        .cdf_valid(cdf_valid), .cdf_ready(cdf_ready), .cdf_bin(cdf_bin),
        .cdf_data(cdf_data), .cdf_last(cdf_last),
        .readout_busy(busy), .readout_done(done)
    );

    histogram_readout_control #(.CDF_WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start_readout(s_start),
        .scratch_mem_read_address(s_rd_addr), .scratch_mem_read_enable(s_rd_en),
        .scratch_mem_read_data(s_rd_data),
        .scratch_mem_write_address(s_wr_addr), .scratch_mem_write_enable(s_wr_en),
        .scratch_mem_write_data(s_wr_data),
        .cdf_valid(s_cdf_valid), .cdf_ready(s_ready), .cdf_bin(s_cdf_bin),
        .cdf_data(s_cdf_data), .cdf_last(s_cdf_last),
        .readout_busy(s_busy), .readout_done(s_done)
    );

    logic [65:0] main_outs;
    logic [61:0] s_outs;
    assign main_outs = {rd_en, rd_addr, wr_en, wr_addr, wr_data, cdf_valid, cdf_bin,
                        cdf_data, cdf_last, busy, done};
    assign s_outs    = {s_rd_en, s_rd_addr, s_wr_en, s_wr_addr, s_wr_data, s_cdf_valid,
                        s_cdf_bin, s_cdf_data, s_cdf_last, s_busy, s_done};

    // scratch memories: data appears 3 cycles after the address cycle
    logic [15:0] mem [NB];
    logic [15:0] init_mem [NB];
    logic [15:0] rd_p0, rd_p1;
    logic        load = 1'b0;
    logic [15:0] mem16 [NB];
    logic [15:0] init_mem16 [NB];
    logic [15:0] s_rd_p0, s_rd_p1;
    logic        load16 = 1'b0;

    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < NB; i++) mem[i] <= init_mem[i];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_p0   <= mem[rd_addr];
        rd_p1   <= rd_p0;
        rd_data <= rd_p1;
    end

    always @(posedge clock) begin
        if (load16) begin
            for (int i = 0; i < NB; i++) mem16[i] <= init_mem16[i];
        end else if (s_wr_en) begin
            mem16[s_wr_addr] <= s_wr_data;
        end
        s_rd_p0   <= mem16[s_rd_addr];
        s_rd_p1   <= s_rd_p0;
        s_rd_data <= s_rd_p1;
    end

    int tests = 0;
    int fails = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic load_main();
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
    endtask

    task automatic run_main(input int stall_pct, input int stall_bin, input int stall_len,
                            input bit mid_start, input bit start_in_done,
                            output int done_rel, output int rd_cnt, output int wr_cnt,
                            output int stalls);
        longint     sum;
        longint     exp_cdf [NB];
        int         k, stall_left;
        bit         held, stalled_once;
        logic [7:0] hold_bin;
        logic [19:0] hold_data;
        sum = 0;
        for (int i = 0; i < NB; i++) begin
            sum += longint'(mem[i]);
            exp_cdf[i] = (sum > CDF_MAX20) ? CDF_MAX20 : sum;
        end
        done_rel = -1; rd_cnt = 0; wr_cnt = 0; stalls = 0; k = 0; stall_left = 0;
        held = 0; stalled_once = 0; hold_bin = '0; hold_data = '0;
        start = 1'b1;
        cdf_ready = 1'b1;
        for (int n = 1; n <= 6000 && done_rel < 0; n++) begin
            @(posedge clock); #1;
            start = mid_start && (n == 300);
            if (rd_en) begin
                rd_cnt++;
                tests++;
                if (rd_addr !== 8'(k)) begin
                    fails++;
                    $display("FAIL read_addr: got %0d expected %0d", rd_addr, k);
                end
            end
            if (wr_en) begin
                wr_cnt++;
                tests++;
                if ({wr_addr, wr_data} !== {8'(k), 16'h0000}) begin
                    fails++;
                    $display("FAIL clear_write: got addr %0d data %h expected addr %0d data 0",
                             wr_addr, wr_data, k);
                end
            end
            if (n == 1) begin
                tests++;
                if (rd_en !== 1'b1) begin
                    fails++;
                    $display("FAIL first_read_cycle: read_enable %b expected 1 at cycle 1", rd_en);
                end
            end
            if (n == 5) begin
                tests++;
                if (wr_en !== 1'b1) begin
                    fails++;
                    $display("FAIL first_clear_cycle: write_enable %b expected 1 at cycle 5", wr_en);
                end
            end
            if (n == 6) begin
                tests++;
                if (cdf_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL first_valid_cycle: cdf_valid %b expected 1 at cycle 6", cdf_valid);
                end
            end
            if (held) begin
                tests++;
                if ({cdf_valid, cdf_bin, cdf_data} !== {1'b1, hold_bin, hold_data}) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b bin=%0d data=%0d expected v=1 bin=%0d data=%0d",
                             cdf_valid, cdf_bin, cdf_data, hold_bin, hold_data);
                end
            end
            if (done) begin
                done_rel = n;
                start = start_in_done;
            end
            if (cdf_valid) begin
                if (int'(cdf_bin) == stall_bin && !stalled_once) begin
                    stall_left = stall_len;
                    stalled_once = 1;
                end
                if (stall_left > 0) begin
                    cdf_ready = 1'b0;
                    stall_left--;
                end else begin
                    cdf_ready = ($urandom_range(99) >= stall_pct);
                end
                if (cdf_ready) begin
                    if (k < NB) begin
                        tests++;
                        if ({cdf_bin, cdf_data, cdf_last} !== {8'(k), 20'(exp_cdf[k]), (k == NB - 1)}) begin
                            fails++;
                            $display("FAIL cdf_word: got bin=%0d data=%0d last=%b expected bin=%0d data=%0d last=%b",
                                     cdf_bin, cdf_data, cdf_last, k, exp_cdf[k], (k == NB - 1));
                        end
                    end
                    k++;
                end else begin
                    stalls++;
                end
                held = !cdf_ready;
                hold_bin = cdf_bin;
                hold_data = cdf_data;
            end else begin
                held = 0;
                cdf_ready = 1'b1;
            end
        end
        tests++;
        if (done_rel < 0 || k != NB) begin
            fails++;
            $display("FAIL readout_complete: done_rel=%0d words=%0d expected done and %0d words",
                     done_rel, k, NB);
        end
        cdf_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            tests++;
            if (main_outs !== '0) begin
                fails++;
                $display("FAIL idle_outputs: got %h expected 0", main_outs);
            end
            tests++;
            if (s_outs !== '0) begin
                fails++;
                $display("FAIL idle_outputs16: got %h expected 0", s_outs);
            end
        end
    endtask

    task automatic check_run(input string name, input int done_rel, input int exp_done,
                             input int rd_cnt, input int wr_cnt);
        int nz;
        tests++;
        if (done_rel != exp_done) begin
            fails++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_rel, exp_done);
        end
        tests++;
        if (rd_cnt != NB || wr_cnt != NB) begin
            fails++;
            $display("FAIL %s_strobes: got reads=%0d writes=%0d expected %0d each",
                     name, rd_cnt, wr_cnt, NB);
        end
        nz = 0;
        for (int i = 0; i < NB; i++) if (mem[i] != 16'h0) nz++;
        tests++;
        if (nz != 0) begin
            fails++;
            $display("FAIL %s_mem_cleared: got %0d nonzero bins expected 0", name, nz);
        end
    endtask

    task automatic test_all_ones();
        int d, r, w, s;
        for (int i = 0; i < NB; i++) init_mem[i] = 16'd1;
        load_main();
        run_main(0, -1, 0, 0, 0, d, r, w, s);
        check_run("all_ones", d, DONE_REL, r, w);
    endtask

    task automatic test_ramp_mid_start();
        int d, r, w, s;
        for (int i = 0; i < NB; i++) init_mem[i] = 16'(i);
        load_main();
        run_main(0, -1, 0, 1, 0, d, r, w, s);
        check_run("ramp", d, DONE_REL, r, w);
    endtask

    task automatic test_stall_bin5();
        int d, r, w, s;
        for (int i = 0; i < NB; i++) init_mem[i] = 16'($urandom_range(0, 300));
        load_main();
        run_main(0, 5, 10, 0, 0, d, r, w, s);
        tests++;
        if (s != 10) begin
            fails++;
            $display("FAIL stall_count: got %0d expected 10", s);
        end
        check_run("stall", d, DONE_REL + 10, r, w);
    endtask

    task automatic test_random_backpressure();
        int d, r, w, s;
        for (int i = 0; i < NB; i++) init_mem[i] = 16'($urandom_range(0, 65535));
        load_main();
        run_main(30, -1, 0, 0, 0, d, r, w, s);
        check_run("random", d, DONE_REL + s, r, w);
    endtask

    task automatic test_back_to_back();
        int d, r, w, s;
        for (int i = 0; i < NB; i++) init_mem[i] = 16'($urandom_range(0, 2000));
        load_main();
        run_main(0, -1, 0, 0, 1, d, r, w, s);
        check_run("b2b_first", d, DONE_REL, r, w);
        @(posedge clock); #1;
        tests++;
        if ({busy, done, rd_en} !== 3'b000) begin
            fails++;
            $display("FAIL start_in_done_ignored: got busy=%b done=%b read=%b expected 0 0 0",
                     busy, done, rd_en);
        end
        run_main(0, -1, 0, 0, 0, d, r, w, s);
        check_run("b2b_second", d, DONE_REL, r, w);
    endtask

    task automatic test_reset_mid();
        logic [15:0] snap [NB];
        bit found;
        int d, r, w, s, bad;
        for (int i = 0; i < NB; i++) begin
            init_mem[i] = 16'($urandom_range(1, 1000));
            snap[i] = init_mem[i];
        end
        load_main();
        start = 1'b1;
        found = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (wr_en && wr_addr == 8'd100) found = 1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL reset_mid_reach: bin 100 clear not seen expected within 2000 cycles");
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        tests++;
        if (main_outs !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h expected 0", main_outs);
        end
        bad = 0;
        for (int i = 0; i < NB; i++) begin
            if (mem[i] !== ((i < 100) ? 16'h0 : snap[i])) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_memory: got %0d wrong bins expected 0", bad);
        end
        run_main(0, -1, 0, 0, 0, d, r, w, s);
        check_run("restart", d, DONE_REL, r, w);
    endtask

    task automatic test_saturation16();
        longint sum;
        longint exp16 [NB];
        int k, done_rel;
        init_mem16[0] = 16'h8000;
        init_mem16[1] = 16'h8000;
        for (int i = 2; i < NB; i++) init_mem16[i] = 16'($urandom_range(0, 50));
        load16 = 1'b1;
        @(posedge clock); #1;
        load16 = 1'b0;
        sum = 0;
        for (int i = 0; i < NB; i++) begin
            sum += longint'(mem16[i]);
            exp16[i] = (sum > CDF_MAX16) ? CDF_MAX16 : sum;
        end
        k = 0;
        done_rel = -1;
        s_start = 1'b1;
        for (int n = 1; n <= 3000 && done_rel < 0; n++) begin
            @(posedge clock); #1;
            s_start = 1'b0;
            if (s_done) done_rel = n;
            if (s_cdf_valid && s_ready && k < NB) begin
                tests++;
                if ({s_cdf_bin, s_cdf_data} !== {8'(k), 16'(exp16[k])}) begin
                    fails++;
                    $display("FAIL sat16_word: got bin=%0d data=%h expected bin=%0d data=%h",
                             s_cdf_bin, s_cdf_data, k, 16'(exp16[k]));
                end
                k++;
            end
        end
        tests++;
        if (done_rel != DONE_REL || k != NB) begin
            fails++;
            $display("FAIL sat16_complete: done_rel=%0d words=%0d expected %0d and %0d",
                     done_rel, k, DONE_REL, NB);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_ramp_mid_start();
        test_stall_bin5();
        test_random_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturation16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/histogram_readout_control.md
# histogram_readout_control

Reads a completed histogram out of scratch memory, one bin per pass, in bin order 0 … NUM_BINS-1. For each bin it accumulates a running cumulative sum (CDF), streams the result over a valid/ready interface, and writes zero back to that bin so scratch memory is clean for the next frame. It sits downstream of histogram_control: start_readout is driven from histogram_computation_done, and it shares the scratch memory port timing of the histogram builder.

## Interface
- NUM_BINS, 256, number of histogram bins (power of two)
- ADDR_WIDTH, 8, scratch memory address width, log2(NUM_BINS)
- BIN_WIDTH, 16, width of one bin count in scratch memory
- CDF_WIDTH, 20, width of the cumulative sum output
- READ_LATENCY, 3, cycles from read address to read data valid (≥2)

Ports:
- clock  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start_readout  in  1  pulse; sampled only in IDLE
- scratch_mem_read_address  out  ADDR_WIDTH  bin address for read
- scratch_mem_read_enable  out  1  read strobe, one cycle per bin
- scratch_mem_read_data  in  BIN_WIDTH  bin count, valid READ_LATENCY cycles after the strobe
- scratch_mem_write_address  out  ADDR_WIDTH  bin address for clear
- scratch_mem_write_enable  out  1  clear strobe, one cycle per bin
- scratch_mem_write_data  out  BIN_WIDTH  always 0
- cdf_valid  out  1  cdf_bin/cdf_data/cdf_last valid
- cdf_ready  in  1  consumer accepts on cdf_valid & cdf_ready
- cdf_bin  out  ADDR_WIDTH  bin index of current CDF word
- cdf_data  out  CDF_WIDTH  cumulative sum of bins 0..cdf_bin
- cdf_last  out  1  high with cdf_valid on bin NUM_BINS-1
- readout_busy  out  1  high in every state except IDLE
- readout_done  out  1  one-cycle pulse at end of readout

## Operation
- States: IDLE, SET_ADDR, WAIT, CAPTURE, CLEAR, OUTPUT, DONE.
- IDLE: bin counter = 0, accumulator = 0. On start_readout, go to SET_ADDR.
- SET_ADDR: read_enable = 1, read_address = bin counter. Go to WAIT.
- WAIT: hold for READ_LATENCY-2 cycles using a down-counter, then go to CAPTURE.
- CAPTURE: cycle at which read data is valid. Register read_data zero-extended into the bin register; accumulator += bin. Go to CLEAR.
- CLEAR: write_enable = 1, write_address = bin counter, write_data = 0. Go to OUTPUT.
- OUTPUT: cdf_valid = 1, cdf_bin = bin counter, cdf_data = accumulator, cdf_last = (bin counter == NUM_BINS-1).
  - Hold all of these stable while cdf_ready = 0.
  - On handshake: if last, go to DONE; otherwise bin counter += 1 and go to SET_ADDR.
- DONE: readout_done = 1 for one cycle. Go to IDLE.
- Arithmetic: the accumulator saturates at 2^CDF_WIDTH-1 and never wraps. The bin counter is ADDR_WIDTH bits; the last bin is detected explicitly, so the counter never wraps to 0 mid-readout.
- start_readout outside IDLE is ignored. A start asserted in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- Exactly one read strobe and one write strobe per bin, regardless of backpressure.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at reset values.
  - Bins already cleared stay zero; the rest are untouched. This is accepted behaviour.
  - No partial write is issued.
- Invalid state encoding: go to IDLE.

## Timing
- Reset values: every output 0, including the address buses and cdf_data.
- Strobes (read_enable, write_enable, readout_done) are one cycle wide, and cdf_valid is a direct state decode. All data and address outputs are driven from registers.
- Start accepted at cycle 0 (IDLE) → SET_ADDR at cycle 1.
- With READ_LATENCY=3 and cdf_ready held high, each bin takes 6 cycles: SET_ADDR, WAIT, CAPTURE, CLEAR, OUTPUT, plus one extra WAIT cycle.
- In general, each bin takes READ_LATENCY+3 cycles.
- Bin k's read strobe is at cycle 1+6k, its clear at 5+6k, and its cdf_valid at 6+6k.
- For NUM_BINS=256: cdf_last handshake at cycle 1536, readout_done at cycle 1537, IDLE at 1538.
- Each stall cycle (cdf_ready = 0) in OUTPUT adds exactly one cycle.

## Test plan
- Reset, then idle 20 cycles with no start → every output 0, no strobes.
- All bins = 1, cdf_ready = 1, start at cycle 0:
  - cdf_data = k+1 for bin k; cdf_last and cdf_data = 256 on bin 255.
  - readout_done at cycle 1537.
  - 256 write strobes, and memory reads all zero afterwards.
- Bins = k (0..255):
  - cdf_data for bin k = k(k+1)/2; final value 32640.
  - A start pulse mid-readout has no effect.
- cdf_ready low for 10 cycles when bin 5 becomes valid:
  - cdf_valid, cdf_bin = 5 and cdf_data stable throughout.
  - No extra read or write strobes.
  - readout_done arrives 10 cycles later than the unstalled case.
- CDF_WIDTH = 16 override, bins 0 and 1 = 0x8000:
  - cdf_data = 0x8000 at bin 0, then 0xFFFF from bin 1 to the end (saturated, no wrap).
- Reset asserted when bin 100 is in CLEAR:
  - All outputs 0 the next cycle; bins 0–99 are zero, bins 100–255 unchanged.
  - A new start restarts at bin 0 with the accumulator at 0.
